adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
//  Capture sequencer between ADC input and fifo_adc write port, clocked by adc_clk.
//  Host latches a config and issues start; block waits a settle delay, arms on immediate/threshold trigger,
//  gates exactly N samples into the FIFO, then reports done/overflow for okPipeOut readback via wire-out status.
// PARAMETERS
//  PRECISION         10  ADC code width (bits)
//  FIFO_COUNT_WIDTH  12  width of FIFO wr_data_count
//  COUNT_WIDTH       16  width of sample/delay counters
// PORTS
//  clk            in   1                 adc_clk domain clock
//  rst            in   1                 asynchronous, active-high reset
//  start          in   1                 1-cycle pulse (synchronized upstream); latches config, begins sequence
//  abort          in   1                 1-cycle pulse; returns to IDLE
//  trig_mode      in   2                 0 immediate, 1 rising threshold, 2 falling threshold, 3 reserved (=0)
//  threshold      in   PRECISION         trigger level (unsigned)
//  delay_count    in   COUNT_WIDTH       settle cycles before arming
//  sample_count   in   COUNT_WIDTH       samples to capture
//  adc_code_in    in   PRECISION         raw ADC code
//  fifo_full      in   1                 FIFO full flag
//  wr_data_count  in   FIFO_COUNT_WIDTH  FIFO fill (status only)
//  fifo_wr_en     out  1                 FIFO write enable (registered)
//  fifo_din       out  PRECISION         FIFO data (registered adc_code_in)
//  busy           out  1                 high in DELAY/ARMED/CAPTURE
//  done           out  1                 sticky; set on completion, cleared by start/abort
//  overflow       out  1                 sticky; FIFO full during capture
//  captured       out  COUNT_WIDTH       samples actually written this run
//  status         out  16                {overflow,done,busy,state[2:0],wr_data_count[9:0]} for okWireOut
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; config regs 0; prev_code 0.
//  start latches trig_mode/threshold/delay_count/sample_count; inputs ignored otherwise. Clears done/overflow/captured.
//  States (state[2:0]): IDLE=0, DELAY=1, ARMED=2, CAPTURE=3, DONE=4.
//   IDLE   : start -> DELAY (delay_count>0) or ARMED (delay_count==0).
//   DELAY  : counter runs delay_count cycles then -> ARMED.
//   ARMED  : mode 0 -> CAPTURE next cycle. Rising: prev_code<threshold && adc_code_in>=threshold.
//            Falling: prev_code>=threshold && adc_code_in<threshold. prev_code reloaded on ARMED entry (no false first-cycle trigger).
//            Triggering sample is the first sample written.
//   CAPTURE: fifo_wr_en=1, fifo_din=adc_code_in registered (1-cycle latency, trigger sample included).
//            Exactly sample_count consecutive wr_en cycles; captured increments per accepted write.
//            fifo_full while fifo_wr_en=1: that write is dropped (not counted), overflow=1, -> DONE immediately.
//   DONE   : done=1, wr_en=0; start -> restart (as from IDLE); abort -> IDLE.
//  sample_count==0 at start: skip DELAY/ARMED/CAPTURE -> DONE next cycle, captured=0, no write.
//  abort in any state: next cycle state=IDLE, fifo_wr_en=0, done stays 0. start+abort same cycle: abort wins.
//  start while busy: ignored (no relatch).
//  Counters saturate at the programmed value; no wrap. sample_count=2^COUNT_WIDTH-1 must complete.
//  Upstream FIFO reset (host ep00[0]) must be paired with abort; block keeps no FIFO-occupancy state.
// STRUCTURE
//  adc_ctrl_defs.vh: localparams for state encodings, TRIG_IMM/TRIG_RISE/TRIG_FALL, status-word bit positions.
//  Sub-module adc_trig_detect: holds prev_code, compares against threshold, outputs 1-cycle trig pulse when enabled.
//  Top: FSM + delay/sample counters + output registers; instantiated between adc_code_in and fifo_adc.din/wr_en.
// TESTING
//  1 mode0, delay=0, N=8, ramp 0..: -> wr_en high 8 cycles, fifo_din 0..7 per trigger alignment, done=1, captured=8.
//  2 mode1, thr=512, input 500,510,520,530: -> first write 520, N writes, nothing written before crossing; start above 512 -> no trigger.
//  3 mode2, thr=100, delay=5: -> busy 5 cycles in DELAY, then arms; first write is first code <100 after code >=100.
//  4 N=20, fifo_full asserted at 10th write: -> captured=9, overflow=1, done=1, wr_en low next cycle.
//  5 abort mid-CAPTURE after 3 writes: -> state IDLE next cycle, wr_en=0, done=0; also start+abort same cycle -> stays IDLE.
//  6 N=0 -> DONE in 1 cycle, no wr_en; async rst during CAPTURE -> all outputs 0 immediately, no clock needed.

Source files
------------

// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl_pkg
//   Shared definitions for the ADC capture sequencer: default widths, FSM state
//   encoding, trigger-mode codes and status-word bit positions.
//   No ports (package).
package adc_capture_ctrl_pkg;

    localparam int DEF_PRECISION        = 10;
    localparam int DEF_FIFO_COUNT_WIDTH = 12;
    localparam int DEF_COUNT_WIDTH      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DELAY   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_RISE = 2'd1;
    localparam logic [1:0] TRIG_FALL = 2'd2;

    // status word: {overflow, done, busy, state[2:0], wr_data_count[9:0]}
    localparam int STAT_OVERFLOW_BIT = 15;
    localparam int STAT_DONE_BIT     = 14;
    localparam int STAT_BUSY_BIT     = 13;
    localparam int STAT_STATE_LSB    = 10;
    localparam int STAT_FILL_WIDTH   = 10;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// adc_capture_ctrl_if
//   Bundles the host control/config inputs, the ADC code input, the FIFO write
//   port and the status readback of the capture sequencer.
//   master : host/ADC/FIFO side (drives start, abort, config, adc_code_in,
//            fifo_full, wr_data_count; observes the rest)
//   slave  : the sequencer (adc_capture_ctrl)
interface adc_capture_ctrl_if
    import adc_capture_ctrl_pkg::*;
#(
    parameter int PRECISION        = DEF_PRECISION,
    parameter int FIFO_COUNT_WIDTH = DEF_FIFO_COUNT_WIDTH,
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
);
    logic                        start;
    logic                        abort;
    logic [1:0]                  trig_mode;
    logic [PRECISION-1:0]        threshold;
    logic [COUNT_WIDTH-1:0]      delay_count;
    logic [COUNT_WIDTH-1:0]      sample_count;
    logic [PRECISION-1:0]        adc_code_in;
    logic                        fifo_full;
    logic [FIFO_COUNT_WIDTH-1:0] wr_data_count;
    logic                        fifo_wr_en;
    logic [PRECISION-1:0]        fifo_din;
    logic                        busy;
    logic                        done;
    logic                        overflow;
    logic [COUNT_WIDTH-1:0]      captured;
    logic [15:0]                 status;

    modport master (
        output start, abort, trig_mode, threshold, delay_count, sample_count,
               adc_code_in, fifo_full, wr_data_count,
        input  fifo_wr_en, fifo_din, busy, done, overflow, captured, status
    );

    modport slave (
        input  start, abort, trig_mode, threshold, delay_count, sample_count,
               adc_code_in, fifo_full, wr_data_count,
        output fifo_wr_en, fifo_din, busy, done, overflow, captured, status
    );

endinterface

// File: rtl/adc_capture_ctrl_trig_detect.sv
// adc_capture_ctrl_trig_detect
//   Holds the previous ADC code and flags a threshold crossing.
//   clk, rst   : adc_clk, async active-high reset
//   en         : detector enabled (sequencer is ARMED)
//   mode       : TRIG_IMM / TRIG_RISE / TRIG_FALL (3 behaves as immediate)
//   threshold  : unsigned trigger level
//   code       : current ADC code
//   trig       : combinational, high for the cycle whose code is the trigger sample
module adc_capture_ctrl_trig_detect
    import adc_capture_ctrl_pkg::*;
#(
    parameter int PRECISION = DEF_PRECISION
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [PRECISION-1:0] threshold,
    input  logic [PRECISION-1:0] code,
    output logic                 trig
);

    logic [PRECISION-1:0] prev_code;
    logic                 hit;

    // Reloaded every cycle, so on the first ARMED cycle prev_code is the code
    // seen just before arming rather than a leftover from an earlier run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_code <= '0;
        end else begin
            prev_code <= code;
        end
    end

    always_comb begin
        hit = 1'b1;
        case (mode)
            TRIG_RISE: hit = (prev_code <  threshold) && (code >= threshold);
            TRIG_FALL: hit = (prev_code >= threshold) && (code <  threshold);
            default:   hit = 1'b1;
        endcase
    end

    assign trig = en & hit;

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl
//   Capture sequencer between the ADC and the fifo_adc write port.
//   start latches the config and runs IDLE -> DELAY -> ARMED -> CAPTURE -> DONE,
//   writing exactly sample_count consecutive codes (trigger sample first).
//   clk  : adc_clk
//   rst  : async active-high reset
//   bus  : adc_capture_ctrl_if.slave (control, config, ADC code, FIFO port, status)
//
//   state   | meaning
//   IDLE    | waiting for start
//   DELAY   | settle timer running (delay_count cycles)
//   ARMED   | waiting for trigger
//   CAPTURE | fifo_wr_en high, one code per cycle
//   DONE    | run finished (done=1), waiting for start/abort
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int PRECISION        = DEF_PRECISION,
    parameter int FIFO_COUNT_WIDTH = DEF_FIFO_COUNT_WIDTH,
    parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    adc_capture_ctrl_if.slave bus
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t                 state_q;
    logic [1:0]             mode_q;
    logic [PRECISION-1:0]   thr_q;
    logic [COUNT_WIDTH-1:0] n_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] captured_q;
    logic [PRECISION-1:0]   din_q;
    logic                   wr_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   overflow_q;
    logic                   trig;
    logic                   unused_fill_msb;

    adc_capture_ctrl_trig_detect #(
        .PRECISION (PRECISION)
    ) u_trig (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == ST_ARMED),
        .mode      (mode_q),
        .threshold (thr_q),
        .code      (bus.adc_code_in),
        .trig      (trig)
    );

    // cnt_q is shared: settle timer in DELAY, remaining samples in CAPTURE.
    // Both count down to a terminal count of 1, so they never wrap and a
    // full-scale sample_count still completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            thr_q      <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            captured_q <= '0;
            din_q      <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.abort) begin
            // The write on the bus this cycle still lands in the FIFO.
            if (wr_en_q && !bus.fifo_full) begin
                captured_q <= captured_q + CNT_ONE;
            end
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        mode_q     <= bus.trig_mode;
                        thr_q      <= bus.threshold;
                        n_q        <= bus.sample_count;
                        captured_q <= '0;
                        overflow_q <= 1'b0;
                        done_q     <= 1'b0;
                        if (bus.sample_count == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (bus.delay_count != '0) begin
                            state_q <= ST_DELAY;
                            cnt_q   <= bus.delay_count;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ARMED;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_ARMED;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        state_q <= ST_CAPTURE;
                        cnt_q   <= n_q;
                        wr_en_q <= 1'b1;
                        din_q   <= bus.adc_code_in;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.fifo_full) begin
                        state_q    <= ST_DONE;
                        overflow_q <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        wr_en_q    <= 1'b0;
                    end else begin
                        captured_q <= captured_q + CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            wr_en_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                            din_q <= bus.adc_code_in;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_din   = din_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
    assign bus.captured   = captured_q;

    // Only the low 10 bits of the FIFO fill fit in the status word.
    assign unused_fill_msb = ^bus.wr_data_count[FIFO_COUNT_WIDTH-1:STAT_FILL_WIDTH];
    assign bus.status = {overflow_q, done_q, busy_q, state_q,
                         bus.wr_data_count[STAT_FILL_WIDTH-1:0]};

endmodule

// File: tb/tb_adc_capture_ctrl.sv
module tb_adc_capture_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adc_capture_ctrl_if bus ();

    adc_capture_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int seq[$];
    int wr_q[$];
    int n_wr;
    int n_delay;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int mode, input int thr, input int dly, input int n);
        bus.trig_mode    = 2'(mode);
        bus.threshold    = 10'(thr);
        bus.delay_count  = 16'(dly);
        bus.sample_count = 16'(n);
    endtask

    // Runs ncyc clock cycles, driving adc_code_in from seq, optionally pulsing
    // start in the first cycle. Records accepted writes into wr_q; when the
    // full_at-th write appears, fifo_full is raised for that cycle.
    task automatic run(input int ncyc, input bit do_start, input int full_at);
        wr_q.delete();
        n_wr = 0;
        n_delay = 0;
        bus.fifo_full = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            bus.adc_code_in = (k < seq.size()) ? 10'(seq[k]) : 10'(seq[seq.size()-1]);
            bus.start = do_start && (k == 0);
            step();
            bus.start = 1'b0;
            if (bus.status[12:10] == 3'd1 && bus.busy) n_delay++;
            bus.fifo_full = 1'b0;
            if (bus.fifo_wr_en) begin
                n_wr++;
                if (n_wr == full_at) bus.fifo_full = 1'b1;
                else wr_q.push_back(int'(bus.fifo_din));
            end
        end
        bus.fifo_full = 1'b0;
    endtask

    function automatic int wr_at(input int i);
        return (i < wr_q.size()) ? wr_q[i] : -1;
    endfunction

    task automatic test_reset();
        vec_cnt++; if (bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL rst_wr_en got %0b exp 0", bus.fifo_wr_en); end
        vec_cnt++; if (bus.status !== 16'h0000) begin err_cnt++; $display("FAIL rst_status got %h exp 0000", bus.status); end
        repeat (2) step();
        rst = 1'b0;
        step();
        vec_cnt++; if (bus.fifo_din !== 10'd0) begin err_cnt++; $display("FAIL idle_din got %0d exp 0", bus.fifo_din); end
        vec_cnt++; if ({bus.busy, bus.done, bus.overflow} !== 3'b000) begin err_cnt++; $display("FAIL idle_flags got %b exp 000", {bus.busy, bus.done, bus.overflow}); end
        vec_cnt++; if (bus.captured !== 16'd0) begin err_cnt++; $display("FAIL idle_captured got %0d exp 0", bus.captured); end
        bus.wr_data_count = 12'hFA5;
        #1;
        vec_cnt++; if (bus.status !== 16'h03A5) begin err_cnt++; $display("FAIL status_fill got %h exp 03a5", bus.status); end
        bus.wr_data_count = 12'h000;
    endtask

    task automatic test_immediate();
        cfg(0, 0, 0, 8);
        seq.delete(); seq.push_back(0);
        for (int i = 0; i < 40; i++) seq.push_back(i);
        run(12, 1'b1, 0);
        vec_cnt++; if (n_wr !== 8) begin err_cnt++; $display("FAIL imm_wr_cycles got %0d exp 8", n_wr); end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++; if (wr_at(i) !== i) begin err_cnt++; $display("FAIL imm_din[%0d] got %0d exp %0d", i, wr_at(i), i); end
        end
        vec_cnt++; if (bus.captured !== 16'd8) begin err_cnt++; $display("FAIL imm_captured got %0d exp 8", bus.captured); end
        vec_cnt++; if (bus.status[15:10] !== 6'b010100) begin err_cnt++; $display("FAIL imm_status got %b exp 010100", bus.status[15:10]); end
    endtask

    task automatic test_rising();
        cfg(1, 512, 0, 4);
        seq.delete();
        for (int i = 0; i < 20; i++) seq.push_back(500 + 10 * i);
        run(12, 1'b1, 0);
        vec_cnt++; if (n_wr !== 4) begin err_cnt++; $display("FAIL rise_wr_cycles got %0d exp 4", n_wr); end
        for (int i = 0; i < 4; i++) begin
            vec_cnt++; if (wr_at(i) !== 520 + 10 * i) begin err_cnt++; $display("FAIL rise_din[%0d] got %0d exp %0d", i, wr_at(i), 520 + 10 * i); end
        end
        vec_cnt++; if (bus.done !== 1'b1 || bus.captured !== 16'd4) begin err_cnt++; $display("FAIL rise_done got %0b/%0d exp 1/4", bus.done, bus.captured); end
        // already above threshold when arming: never triggers
        seq.delete(); seq.push_back(600);
        run(8, 1'b1, 0);
        vec_cnt++; if (n_wr !== 0 || bus.status[12:10] !== 3'd2) begin err_cnt++; $display("FAIL rise_above got wr %0d state %0d exp 0/2", n_wr, bus.status[12:10]); end
        // start while busy: immediate mode must not be relatched
        cfg(0, 0, 0, 4);
        run(4, 1'b1, 0);
        vec_cnt++; if (n_wr !== 0 || bus.status[12:10] !== 3'd2) begin err_cnt++; $display("FAIL busy_start got wr %0d state %0d exp 0/2", n_wr, bus.status[12:10]); end
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        vec_cnt++; if (bus.status[12:10] !== 3'd0 || bus.busy !== 1'b0) begin err_cnt++; $display("FAIL armed_abort got state %0d busy %0b exp 0/0", bus.status[12:10], bus.busy); end
    endtask

    task automatic test_falling_delay();
        cfg(2, 100, 5, 3);
        seq = '{150, 150, 50, 150, 150, 150, 150, 120, 110, 90, 80, 70, 60, 50};
        run(20, 1'b1, 0);
        vec_cnt++; if (n_delay !== 5) begin err_cnt++; $display("FAIL delay_cycles got %0d exp 5", n_delay); end
        vec_cnt++; if (n_wr !== 3) begin err_cnt++; $display("FAIL fall_wr_cycles got %0d exp 3", n_wr); end
        vec_cnt++; if (wr_at(0) !== 90 || wr_at(1) !== 80 || wr_at(2) !== 70) begin err_cnt++; $display("FAIL fall_din got %0d,%0d,%0d exp 90,80,70", wr_at(0), wr_at(1), wr_at(2)); end
    endtask

    task automatic test_overflow();
        cfg(0, 0, 0, 20);
        seq.delete(); seq.push_back(0);
        for (int i = 0; i < 40; i++) seq.push_back(i);
        run(30, 1'b1, 10);
        vec_cnt++; if (n_wr !== 10) begin err_cnt++; $display("FAIL ovf_wr_cycles got %0d exp 10", n_wr); end
        vec_cnt++; if (bus.captured !== 16'd9) begin err_cnt++; $display("FAIL ovf_captured got %0d exp 9", bus.captured); end
        vec_cnt++; if (wr_at(8) !== 8) begin err_cnt++; $display("FAIL ovf_last_din got %0d exp 8", wr_at(8)); end
        vec_cnt++; if (bus.status[15:10] !== 6'b110100) begin err_cnt++; $display("FAIL ovf_status got %b exp 110100", bus.status[15:10]); end
    endtask

    task automatic test_abort();
        cfg(0, 0, 0, 10);
        seq.delete(); seq.push_back(0);
        for (int i = 0; i < 40; i++) seq.push_back(i);
        run(4, 1'b1, 0);
        vec_cnt++; if (n_wr !== 3) begin err_cnt++; $display("FAIL abort_pre_writes got %0d exp 3", n_wr); end
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        vec_cnt++; if (bus.status[15:10] !== 6'b000000 || bus.fifo_wr_en !== 1'b0) begin err_cnt++; $display("FAIL abort_cap got %b wr %0b exp 000000/0", bus.status[15:10], bus.fifo_wr_en); end
        vec_cnt++; if (bus.captured !== 16'd3) begin err_cnt++; $display("FAIL abort_captured got %0d exp 3", bus.captured); end
        bus.start = 1'b1; bus.abort = 1'b1; step(); bus.start = 1'b0; bus.abort = 1'b0;
        vec_cnt++; if (bus.status[12:10] !== 3'd0 || bus.busy !== 1'b0) begin err_cnt++; $display("FAIL start_abort got state %0d busy %0b exp 0/0", bus.status[12:10], bus.busy); end
        run(5, 1'b0, 0);
        vec_cnt++; if (n_wr !== 0 || bus.status[12:10] !== 3'd0) begin err_cnt++; $display("FAIL stay_idle got wr %0d state %0d exp 0/0", n_wr, bus.status[12:10]); end
    endtask

    task automatic test_zero_and_async_reset();
        cfg(0, 0, 7, 0);
        run(1, 1'b1, 0);
        vec_cnt++; if (bus.status[15:10] !== 6'b010100 || n_wr !== 0) begin err_cnt++; $display("FAIL n0_done got %b wr %0d exp 010100/0", bus.status[15:10], n_wr); end
        vec_cnt++; if (bus.captured !== 16'd0) begin err_cnt++; $display("FAIL n0_captured got %0d exp 0", bus.captured); end
        cfg(0, 0, 0, 10);
        seq.delete(); seq.push_back(5);
        for (int i = 0; i < 20; i++) seq.push_back(100 + i);
        run(4, 1'b1, 0);
        vec_cnt++; if (bus.status[12:10] !== 3'd3 || bus.fifo_wr_en !== 1'b1) begin err_cnt++; $display("FAIL pre_rst_capture got state %0d wr %0b exp 3/1", bus.status[12:10], bus.fifo_wr_en); end
        #2;
        rst = 1'b1;
        #1;
        vec_cnt++; if ({bus.fifo_wr_en, bus.busy, bus.done, bus.overflow} !== 4'b0000) begin err_cnt++; $display("FAIL async_rst_flags got %b exp 0000", {bus.fifo_wr_en, bus.busy, bus.done, bus.overflow}); end
        vec_cnt++; if (bus.fifo_din !== 10'd0 || bus.captured !== 16'd0) begin err_cnt++; $display("FAIL async_rst_data got %0d/%0d exp 0/0", bus.fifo_din, bus.captured); end
        vec_cnt++; if (bus.status !== 16'h0000) begin err_cnt++; $display("FAIL async_rst_status got %h exp 0000", bus.status); end
        rst = 1'b0;
        step();
        vec_cnt++; if (bus.status[12:10] !== 3'd0) begin err_cnt++; $display("FAIL post_rst_state got %0d exp 0", bus.status[12:10]); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.trig_mode = 2'd0;
        bus.threshold = '0;
        bus.delay_count = '0;
        bus.sample_count = '0;
        bus.adc_code_in = '0;
        bus.fifo_full = 1'b0;
        bus.wr_data_count = '0;
        #3;
        test_reset();
        test_immediate();
        test_rising();
        test_falling_delay();
        test_overflow();
        test_abort();
        test_zero_and_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
